// File: rtl/uP16_pkg.sv
// -----------------------------------------------------------------------------
// uP16_pkg
// Shared definitions for the uP16 fetch path:
//   - fetch FSM state encoding
//   - default instruction address / data widths
//   - NOP instruction encoding shown to decode when no instruction is live
// -----------------------------------------------------------------------------
package uP16_pkg;

    localparam int P_AWIDTH = 10;
    localparam int P_DWIDTH = 18;

    localparam logic [17:0] P_NOP = 18'h00000;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch sequencer sitting between the synchronous instruction ROM
// and the decode stage. Owns the program counter, drives the ROM address every
// cycle, hides the ROM's one-cycle read latency and presents one instruction
// per cycle with a valid flag. Supports stall (re-read), branch redirect
// (squashes the instruction shown in the same cycle) and halt.
//
// Ports:
//   Clk_In            system clock, rising edge
//   Reset_In          synchronous active-high reset
//   Stall_In          decode not ready, hold the current instruction
//   Branch_In         redirect request from a later stage
//   Branch_Target_In  redirect address
//   Halt_In           decode recognised a halt in the current instruction
//   Mem_Add_Out       ROM address (combinational)
//   Mem_Data_In       ROM data, valid one cycle after the address
//   Instr_Out         current instruction (NOP when not valid)
//   PC_Out            address of Instr_Out
//   Valid_Out         Instr_Out is a live instruction
//   Halted_Out        fetch stopped
//   Fetch_Count_Out   saturating count of instructions accepted by decode
// -----------------------------------------------------------------------------
module if_fetch_ctrl
    import uP16_pkg::*;
#(
    parameter int                 AWIDTH   = P_AWIDTH,
    parameter int                 DWIDTH   = P_DWIDTH,
    parameter logic [AWIDTH-1:0]  RESET_PC = 10'h000,
    parameter logic [DWIDTH-1:0]  NOP      = P_NOP,
    parameter int                 CWIDTH   = 16
) (
    input  logic              Clk_In,
    input  logic              Reset_In,
    input  logic              Stall_In,
    input  logic              Branch_In,
    input  logic [AWIDTH-1:0] Branch_Target_In,
    input  logic              Halt_In,
    output logic [AWIDTH-1:0] Mem_Add_Out,
    input  logic [DWIDTH-1:0] Mem_Data_In,
    output logic [DWIDTH-1:0] Instr_Out,
    output logic [AWIDTH-1:0] PC_Out,
    output logic              Valid_Out,
    output logic              Halted_Out,
    output logic [CWIDTH-1:0] Fetch_Count_Out
);

    localparam logic [AWIDTH-1:0] PC_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CWIDTH-1:0] CNT_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};

    fetch_state_e      state_r;
    // Address presented last cycle, i.e. the address whose data is on Mem_Data_In.
    logic [AWIDTH-1:0] pc_r;
    logic [CWIDTH-1:0] cnt_r;

    logic [AWIDTH-1:0] mem_add_s;
    logic              valid_s;
    logic              accept_s;

    // A branch squashes whatever instruction is on display this cycle.
    assign valid_s  = (state_r == S_RUN) & ~Branch_In;
    assign accept_s = valid_s & ~Stall_In;

    // Next ROM address: reset, then branch, then stall re-read, then sequential.
    always_comb begin
        mem_add_s = pc_r;
        if (Reset_In) begin
            mem_add_s = RESET_PC;
        end else begin
            case (state_r)
                S_RUN: begin
                    if (Branch_In) begin
                        mem_add_s = Branch_Target_In;
                    end else if (Stall_In) begin
                        // Re-read the same address so the ROM output stays put.
                        mem_add_s = pc_r;
                    end else begin
                        // Natural modulo-2^AWIDTH wrap.
                        mem_add_s = pc_r + PC_ONE;
                    end
                end
                S_INIT:  mem_add_s = pc_r;
                S_HALT:  mem_add_s = pc_r;
                default: mem_add_s = pc_r;
            endcase
        end
    end

    // FSM, program counter and saturating fetch counter.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_r <= S_INIT;
            pc_r    <= RESET_PC;
            cnt_r   <= {CWIDTH{1'b0}};
        end else begin
            pc_r <= mem_add_s;

            case (state_r)
                S_INIT: state_r <= S_RUN;
                S_RUN: begin
                    // A halt under stall waits until decode actually takes it.
                    if (Halt_In & accept_s) begin
                        state_r <= S_HALT;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_HALT:  state_r <= S_HALT;
                default: state_r <= S_INIT;
            endcase

            if (accept_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign Mem_Add_Out     = mem_add_s;
    assign Valid_Out       = valid_s;
    assign Instr_Out       = valid_s ? Mem_Data_In : NOP;
    assign PC_Out          = pc_r;
    assign Halted_Out      = (state_r == S_HALT);
    assign Fetch_Count_Out = cnt_r;

endmodule
